// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared defaults, types and the clear-engine state encoding for the
// vector/scalar register file (vs_regfile_sb) and its scoreboard.
//   LANES_D / XLEN_D / NREGS_D : default geometry (16 lanes x 32 bits, 16 regs)
//   lane_t / vec_t             : one lane / one full vector row at the defaults
//   clr_state_e                : clear FSM states
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int LANES_D = 16;
    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 16;

    typedef logic [XLEN_D-1:0]  lane_t;
    typedef lane_t [LANES_D-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Busy bits for the vector and scalar register spaces. A reservation marks a
// register as having a pending producer; a write in the matching space
// retires it. When a register is reserved and written in the same cycle the
// reservation wins, since it belongs to a newer producer. flush zeroes all
// bits (used at the end of a file clear).
// Ports:
//   clk, rst                      clock, async active-high reset
//   set_en/set_addr/set_vec       reservation request (vec=1 vector space)
//   clr_en/clr_addr/clr_vec       retire request from a write
//   flush                         clear every busy bit
//   busy_v, busy_s                busy bits per register, vector / scalar
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS = NREGS_D,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             set_vec,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic             clr_vec,
    input  logic             flush,
    output logic [NREGS-1:0] busy_v,
    output logic [NREGS-1:0] busy_s
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    logic [NREGS-1:0] set_v, set_s, clr_v, clr_s;

    always_comb begin
        set_v = '0;
        set_s = '0;
        clr_v = '0;
        clr_s = '0;
        if (set_en) begin
            if (set_vec)
                set_v[set_addr] = 1'b1;
            else if (set_addr != LAST)   // scalar top index is pc, never pending
                set_s[set_addr] = 1'b1;
        end
        if (clr_en) begin
            if (clr_vec)
                clr_v[clr_addr] = 1'b1;
            else
                clr_s[clr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_v <= '0;
            busy_s <= '0;
        end else if (flush) begin
            busy_v <= '0;
            busy_s <= '0;
        end else begin
            // set is OR-ed after the clear so a same-cycle reservation survives
            busy_v <= set_v | (busy_v & ~clr_v);
            busy_s <= set_s | (busy_s & ~clr_s);
        end
    end

endmodule

// File: rtl/vs_regfile_sb.sv
// ---------------------------------------------------------------------------
// vs_regfile_sb
// Vector/scalar register file for the SIMD datapath with per-lane write
// masking, a busy scoreboard for multi-cycle producers and a sequential
// clear engine that zeroes the file one index per cycle.
// Optional feature: define RF_WR_BYPASS_EN to forward same-cycle write data
// to matching read ports; otherwise writes are visible the next cycle.
// Ports:
//   clk, rst               clock, async active-high reset
//   ra1, ra2, rsel_vec     read addresses, view select (1 = vector view)
//   pc_in                  returned in the top lane for scalar reads of NREGS-1
//   rd1, rd2               combinational read data (LANES x XLEN)
//   we, wa, wsel_vec       write enable / address / space (1 = vector)
//   wmask, wd              per-lane write mask (vector only), write data
//   rsv_en/rsv_addr/rsv_vec  reserve a register in the busy scoreboard
//   busy_v, busy_s         busy bits
//   clr_req                start clear (sampled in IDLE)
//   clr_busy, clr_done     clear in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module vs_regfile_sb
    import rf_pkg::*;
#(
    parameter  int LANES = LANES_D,
    parameter  int XLEN  = XLEN_D,
    parameter  int NREGS = NREGS_D,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AW-1:0]              ra1,
    input  logic [AW-1:0]              ra2,
    input  logic                       rsel_vec,
    input  logic [XLEN-1:0]            pc_in,
    output logic [LANES-1:0][XLEN-1:0] rd1,
    output logic [LANES-1:0][XLEN-1:0] rd2,
    input  logic                       we,
    input  logic [AW-1:0]              wa,
    input  logic                       wsel_vec,
    input  logic [LANES-1:0]           wmask,
    input  logic [LANES-1:0][XLEN-1:0] wd,
    input  logic                       rsv_en,
    input  logic [AW-1:0]              rsv_addr,
    input  logic                       rsv_vec,
    output logic [NREGS-1:0]           busy_v,
    output logic [NREGS-1:0]           busy_s,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef logic [LANES-1:0][XLEN-1:0] vrow_t;

    vrow_t           vreg [NREGS];
    logic [XLEN-1:0] sreg [NREGS];

    clr_state_e      state, state_nxt;
    logic [AW-1:0]   idx, idx_nxt;

    logic            idle;
    logic            wr_ok;
    logic            rsv_ok;

    // Writes and reservations are only honoured while the clear engine is idle.
    assign idle   = (state == IDLE);
    assign wr_ok  = we & idle;
    assign rsv_ok = rsv_en & idle;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                idx_nxt = idx + 1'b1;
                if (idx == LAST)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_busy = (state != IDLE);
    assign clr_done = (state == DONE);

    // ---------------- storage ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                vreg[r] <= '0;
                sreg[r] <= '0;
            end
        end else if (state == CLEAR) begin
            vreg[idx] <= '0;
            sreg[idx] <= '0;
        end else if (wr_ok) begin
            if (wsel_vec) begin
                for (int l = 0; l < LANES; l++)
                    if (wmask[l])
                        vreg[wa][l] <= wd[l];
            end else if (wa != LAST) begin
                // scalar top index aliases pc_in and has no storage semantics
                sreg[wa] <= wd[LANES-1];
            end
        end
    end

    // ---------------- read ports ----------------
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [AW-1:0] ra;
        vrow_t         rd;

        assign ra = (p == 0) ? ra1 : ra2;

        always_comb begin
            rd = vreg[ra];
            // scalar view: top lane is the scalar register, lower lanes stay vector
            if (!rsel_vec)
                rd[LANES-1] = (ra == LAST) ? pc_in : sreg[ra];
`ifdef RF_WR_BYPASS_EN
            if (wr_ok && (ra == wa) && (rsel_vec == wsel_vec)) begin
                if (wsel_vec) begin
                    for (int l = 0; l < LANES; l++)
                        if (wmask[l])
                            rd[l] = wd[l];
                end else if (ra != LAST) begin
                    rd[LANES-1] = wd[LANES-1];
                end
            end
`endif
        end
    end

    assign rd1 = g_rd[0].rd;
    assign rd2 = g_rd[1].rd;

    // ---------------- scoreboard ----------------
    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (rsv_ok),
        .set_addr (rsv_addr),
        .set_vec  (rsv_vec),
        .clr_en   (wr_ok),
        .clr_addr (wa),
        .clr_vec  (wsel_vec),
        .flush    (state == DONE),
        .busy_v   (busy_v),
        .busy_s   (busy_s)
    );

endmodule
